// File: rtl/lut_fifo_ctrl_if.sv
// lut_fifo_ctrl_if -- bundles the FIFO user handshake and the LUT RAM ports
// of lut_fifo_ctrl.
//
// Signal names match the controller's original port names.
//
// Push side:
//   iWD, iWE     push data / request
//   oFull        no free entry
//   oAlmostFull  level at or above threshold
//
// Pop side:
//   oRD          head-of-FIFO data, first-word fall-through
//   iRE          pop request
//   oEmpty       no valid entry
//   oCount       current level
//
// RAM side:
//   oRamWD, oRamWA, oRamWE  RAM write port
//   oRamRA, iRamRD          RAM asynchronous read port
//
// Modports:
//   slave   the controller
//   master  the surrounding logic (user plus RAM)

interface lut_fifo_ctrl_if #(
  parameter int pBitWidth  = 32,
  parameter int pAddrWidth = 8
);
  logic [pBitWidth-1:0]  iWD;
  logic                  iWE;
  logic                  oFull;
  logic                  oAlmostFull;
  logic [pBitWidth-1:0]  oRD;
  logic                  iRE;
  logic                  oEmpty;
  logic [pAddrWidth:0]   oCount;
  logic [pBitWidth-1:0]  oRamWD;
  logic [pAddrWidth-1:0] oRamWA;
  logic                  oRamWE;
  logic [pAddrWidth-1:0] oRamRA;
  logic [pBitWidth-1:0]  iRamRD;

  modport slave (
    input  iWD, iWE, iRE, iRamRD,
    output oFull, oAlmostFull, oRD, oEmpty, oCount,
           oRamWD, oRamWA, oRamWE, oRamRA
  );

  modport master (
    output iWD, iWE, iRE, iRamRD,
    input  oFull, oAlmostFull, oRD, oEmpty, oCount,
           oRamWD, oRamWA, oRamWE, oRamRA
  );
endinterface

// File: rtl/lut_fifo_ctrl.sv
// lut_fifo_ctrl -- FIFO controller around an external zero-read-latency
// LUT RAM.
//
// The controller owns the pointers and flags. Data never passes through a
// register: pushes go straight to the RAM write port, and the head word is
// read back asynchronously. A pushed word is therefore visible on oRD one
// cycle later.
//
// Parameters:
//   pBuffDepth   depth in words; power of two, >= 2
//   pBitWidth    data width
//   pAddrWidth   log2(pBuffDepth)
//   pAlmostFull  oAlmostFull threshold, 1..pBuffDepth
//
// Ports:
//   iCLK  clock, rising edge
//   iRST  synchronous active-high reset
//   bus   lut_fifo_ctrl_if.slave (push, pop, RAM signals)
//
// Build option:
//   LUT_FIFO_ERR_FLAG_EN
//     Adds sticky oOvf (push while full) and oUdf (pop while empty).
//     Both flags are cleared by iRST.

module lut_fifo_ctrl #(
  parameter int pBuffDepth  = 256,
  parameter int pBitWidth   = 32,
  parameter int pAddrWidth  = 8,
  parameter int pAlmostFull = 240
) (
  input  logic           iCLK,
  input  logic           iRST,
  lut_fifo_ctrl_if.slave bus
`ifdef LUT_FIFO_ERR_FLAG_EN
  ,
  output logic           oOvf,
  output logic           oUdf
`endif
);

  if (pBuffDepth != (1 << pAddrWidth) || pBuffDepth < 2) begin : gBadDepth
    $error("lut_fifo_ctrl: pBuffDepth must be 2**pAddrWidth and >= 2");
  end
  if (pAlmostFull < 1 || pAlmostFull > pBuffDepth) begin : gBadAlmostFull
    $error("lut_fifo_ctrl: pAlmostFull out of range 1..pBuffDepth");
  end

  localparam logic [pAddrWidth:0] cAlmostFull = (pAddrWidth+1)'(pAlmostFull);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [pAddrWidth:0]   wPtr;
  logic [pAddrWidth:0]   rPtr;
  logic [pAddrWidth:0]   level;
  logic                  full;
  logic                  empty;
  logic                  pushOk;
  logic                  popOk;
  logic [pBitWidth-1:0]  pushData;
  logic [pBitWidth-1:0]  headData;

  // Flags and level come only from the pointer registers.
  assign empty = (wPtr == rPtr);
  assign full  = (wPtr[pAddrWidth] != rPtr[pAddrWidth]) &&
                 (wPtr[pAddrWidth-1:0] == rPtr[pAddrWidth-1:0]);
  assign level = wPtr - rPtr;

  // Each request is qualified against the pre-edge flags on its own. A
  // simultaneous push and pop on a full FIFO keeps only the pop, and on an
  // empty FIFO keeps only the push.
  assign pushOk = bus.iWE & ~full;
  assign popOk  = bus.iRE & ~empty;

  assign pushData = bus.iWD;
  assign headData = bus.iRamRD;

  always_comb begin
    bus.oFull       = full;
    bus.oEmpty      = empty;
    bus.oCount      = level;
    bus.oAlmostFull = (level >= cAlmostFull);
    bus.oRamWD      = pushData;
    bus.oRamWA      = wPtr[pAddrWidth-1:0];
    bus.oRamWE      = pushOk & ~iRST;
    bus.oRamRA      = rPtr[pAddrWidth-1:0];
    bus.oRD         = headData;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wPtr <= '0;
      rPtr <= '0;
    end else begin
      if (pushOk) wPtr <= wPtr + 1'b1;
      if (popOk)  rPtr <= rPtr + 1'b1;
    end
  end

`ifdef LUT_FIFO_ERR_FLAG_EN
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oOvf <= 1'b0;
      oUdf <= 1'b0;
    end else begin
      if (bus.iWE && full)  oOvf <= 1'b1;
      if (bus.iRE && empty) oUdf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lut_fifo_ctrl.sv
module tb_lut_fifo_ctrl;
  localparam int cDepth = 4;
  localparam int cAw    = 2;
  localparam int cBw    = 8;
  localparam int cAf    = 3;

  logic iCLK = 1'b0;
  logic iRST;
  always #5 iCLK = ~iCLK;

  lut_fifo_ctrl_if #(.pBitWidth(cBw), .pAddrWidth(cAw)) bus ();

`ifdef LUT_FIFO_ERR_FLAG_EN
  logic oOvf, oUdf;
`endif

  lut_fifo_ctrl #(
    .pBuffDepth (cDepth),
    .pBitWidth  (cBw),
    .pAddrWidth (cAw),
    .pAlmostFull(cAf)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus.slave)
`ifdef LUT_FIFO_ERR_FLAG_EN
    ,
    .oOvf(oOvf),
    .oUdf(oUdf)
`endif
  );

  // LUT RAM: synchronous write, asynchronous read, never cleared.
  logic [cBw-1:0] ram [cDepth];
  always @(posedge iCLK) if (bus.oRamWE) ram[bus.oRamWA] <= bus.oRamWD;
  assign bus.iRamRD = ram[bus.oRamRA];

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic checkState(input string tag, input int cnt, input logic emp,
                            input logic ful, input logic af);
    checkVal({tag, ".count"}, 32'(bus.oCount), 32'(cnt));
    checkVal({tag, ".empty"}, 32'(bus.oEmpty), 32'(emp));
    checkVal({tag, ".full"},  32'(bus.oFull),  32'(ful));
    checkVal({tag, ".af"},    32'(bus.oAlmostFull), 32'(af));
  endtask

  logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] expRd;

  initial begin
    iRST = 1'b1; bus.iWE = 1'b0; bus.iRE = 1'b0; bus.iWD = '0;
    for (int i = 0; i < 4; i++) ram[i] = 8'hFF;
    tick(); tick();
    iRST = 1'b0;
    checkState("reset", 0, 1'b1, 1'b0, 1'b0);
`ifdef LUT_FIFO_ERR_FLAG_EN
    checkVal("reset.ovf", 32'(oOvf), 32'd0);
    checkVal("reset.udf", 32'(oUdf), 32'd0);
`endif

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      bus.iWD = fill[i]; bus.iWE = 1'b1;
      #1;
      checkVal("fill.ramwe", 32'(bus.oRamWE), 32'd1);
      checkVal("fill.ramwa", 32'(bus.oRamWA), 32'(i));
      tick();
      checkState("fill", i + 1, 1'b0, (i == 3), (i >= 2));
      checkVal("fill.head", 32'(bus.oRD), 32'h11);
    end

    // Push while full is dropped
    bus.iWD = 8'h55;
    #1;
    checkVal("ovf.ramwe", 32'(bus.oRamWE), 32'd0);
    tick();
    bus.iWE = 1'b0;
    checkState("ovf", 4, 1'b0, 1'b1, 1'b1);
`ifdef LUT_FIFO_ERR_FLAG_EN
    checkVal("ovf.flag", 32'(oOvf), 32'd1);
`endif

    // Drain
    for (int i = 0; i < 4; i++) begin
      bus.iRE = 1'b1;
      #1;
      checkVal("drain.rd", 32'(bus.oRD), 32'(fill[i]));
      tick();
    end
    checkState("drain", 0, 1'b1, 1'b0, 1'b0);

    // Pop while empty is ignored
    checkVal("udf.ra_pre", 32'(bus.oRamRA), 32'd0);
    tick();
    bus.iRE = 1'b0;
    checkState("udf", 0, 1'b1, 1'b0, 1'b0);
    checkVal("udf.ra", 32'(bus.oRamRA), 32'd0);
`ifdef LUT_FIFO_ERR_FLAG_EN
    checkVal("udf.flag", 32'(oUdf), 32'd1);
`endif

    // Push+pop while empty: only the push lands
    bus.iWE = 1'b1; bus.iRE = 1'b1; bus.iWD = 8'hA0;
    tick();
    bus.iRE = 1'b0;
    checkState("pp_empty", 1, 1'b0, 1'b0, 1'b0);
    checkVal("pp_empty.rd", 32'(bus.oRD), 32'hA0);
    bus.iWD = 8'hA1;
    tick();
    checkState("hold2", 2, 1'b0, 1'b0, 1'b0);

    // Steady push+pop at level 2 across pointer wrap
    bus.iRE = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.iWD = 8'(8'hB0 + k);
      expRd = (k < 2) ? 8'(8'hA0 + k) : 8'(8'hB0 + k - 2);
      #1;
      checkVal("stream.rd", 32'(bus.oRD), 32'(expRd));
      tick();
      checkVal("stream.count", 32'(bus.oCount), 32'd2);
    end
    bus.iRE = 1'b0;

    // Refill to full: holds B8,B9,C0,C1
    bus.iWD = 8'hC0; tick();
    bus.iWD = 8'hC1; tick();
    checkState("refill", 4, 1'b0, 1'b1, 1'b1);

    // Push+pop while full: only the pop lands
    bus.iRE = 1'b1; bus.iWD = 8'hEE;
    #1;
    checkVal("pp_full.ramwe", 32'(bus.oRamWE), 32'd0);
    checkVal("pp_full.rd", 32'(bus.oRD), 32'hB8);
    tick();
    bus.iWE = 1'b0; bus.iRE = 1'b0;
    checkState("pp_full", 3, 1'b0, 1'b0, 1'b1);
    checkVal("pp_full.head", 32'(bus.oRD), 32'hB9);

    // Reset at level 3 with a push pending
    iRST = 1'b1; bus.iWE = 1'b1; bus.iWD = 8'h77;
    #1;
    checkVal("rst.ramwe", 32'(bus.oRamWE), 32'd0);
    tick();
    iRST = 1'b0; bus.iWE = 1'b0;
    checkState("rst", 0, 1'b1, 1'b0, 1'b0);
`ifdef LUT_FIFO_ERR_FLAG_EN
    checkVal("rst.ovf", 32'(oOvf), 32'd0);
    checkVal("rst.udf", 32'(oUdf), 32'd0);
`endif

    // Fresh push after reset shows new data only
    bus.iWE = 1'b1; bus.iWD = 8'h12;
    tick();
    bus.iWE = 1'b0;
    checkState("post_rst", 1, 1'b0, 1'b0, 1'b0);
    checkVal("post_rst.rd", 32'(bus.oRD), 32'h12);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/lut_fifo_ctrl.md
LUT_FIFO_CTRL -- requirements
Module: lut_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter pBuffDepth, default 256, FIFO depth in words; must be a power of two and at least 2.
REQ-002 The block SHALL have parameter pBitWidth, default 32, data word width.
REQ-003 The block SHALL have parameter pAddrWidth, default 8, RAM address width; must equal log2(pBuffDepth).
REQ-004 The block SHALL have parameter pAlmostFull, default 240, level at or above which oAlmostFull asserts; range 1..pBuffDepth.
REQ-005 The block SHALL have port iCLK, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port iRST, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port iWD, input, pBitWidth bits, push data.
REQ-008 The block SHALL have port iWE, input, 1 bit, push request.
REQ-009 The block SHALL have port oFull, output, 1 bit, no free entry.
REQ-010 The block SHALL have port oAlmostFull, output, 1 bit, level >= pAlmostFull.
REQ-011 The block SHALL have port oRD, output, pBitWidth bits, head-of-FIFO data (first-word fall-through).
REQ-012 The block SHALL have port iRE, input, 1 bit, pop request.
REQ-013 The block SHALL have port oEmpty, output, 1 bit, no valid entry; oRD valid only while low.
REQ-014 The block SHALL have port oCount, output, pAddrWidth+1 bits, current level 0..pBuffDepth.
REQ-015 The block SHALL have ports oRamWD (output, pBitWidth bits), oRamWA (output, pAddrWidth bits) and oRamWE (output, 1 bit), driving the write port of the zero-read-latency LUT RAM.
REQ-016 The block SHALL have ports oRamRA (output, pAddrWidth bits) and iRamRD (input, pBitWidth bits), the asynchronous read port of that RAM.

Function
REQ-017 The block SHALL keep write and read pointers of pAddrWidth+1 bits; the low pAddrWidth bits address the RAM, and the MSB is the wrap bit.
REQ-018 The block SHALL accept a push when iWE=1 and oFull=0, with oRamWE=iWE&~oFull, oRamWA=wptr[pAddrWidth-1:0] and oRamWD=iWD, all combinational.
REQ-019 The block SHALL advance wptr by 1 on the clock edge of an accepted push, wrapping modulo 2*pBuffDepth.
REQ-020 The block SHALL accept a pop when iRE=1 and oEmpty=0, and SHALL advance rptr by 1 on that edge.
REQ-021 The block SHALL drive oRamRA=rptr[pAddrWidth-1:0] and oRD=iRamRD combinationally, so no read latency is added.
REQ-022 The block SHALL assert oEmpty when wptr==rptr.
REQ-023 The block SHALL assert oFull when the pointer MSBs differ and the low bits are equal.
REQ-024 The block SHALL derive oCount=wptr-rptr modulo 2^(pAddrWidth+1), and oFull, oEmpty, oCount and oAlmostFull SHALL depend only on registers.
REQ-025 The block SHALL make a word pushed in cycle N visible on oRD, with oEmpty=0, in cycle N+1.
REQ-026 The block SHALL ignore a push while full: no RAM write, no pointer change.
REQ-027 The block SHALL ignore a pop while empty: no pointer change.
REQ-028 On simultaneous iWE and iRE, each request SHALL be qualified independently against pre-edge flags. When full, only the pop is accepted. When empty, only the push is accepted. Otherwise both are accepted and oCount is unchanged.

Reset
REQ-029 On iRST=1 at a clock edge, the block SHALL clear wptr and rptr to 0, giving oEmpty=1, oFull=0, oAlmostFull=0 and oCount=0 from the next cycle.
REQ-030 iRST SHALL override iWE and iRE in the same cycle, and oRamWE SHALL be forced to 0 while iRST=1.
REQ-031 Reset mid-operation SHALL discard all stored words; RAM contents are not cleared and are not visible afterwards.

Configuration
REQ-032 With LUT_FIFO_ERR_FLAG_EN defined, the block SHALL add outputs oOvf and oUdf (1 bit each). oOvf sets on a push while full, oUdf sets on a pop while empty; both are sticky until iRST and reset to 0.
REQ-033 Without LUT_FIFO_ERR_FLAG_EN, the ports oOvf and oUdf and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (pBuffDepth=4, pAddrWidth=2, pAlmostFull=3, pBitWidth=8)
REQ-034 Bench scenario: reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles -> oCount 1,2,3,4; oAlmostFull=1 after the third push; oFull=1 after the fourth; oRD=0x11 from the cycle after the first push.
REQ-035 Bench scenario: while full, push 0x55 -> oRamWE=0 and oCount stays 4; with the macro defined, oOvf=1. Then pop four times -> oRD sequence 0x11,0x22,0x33,0x44, ending with oEmpty=1.
REQ-036 Bench scenario: while empty, assert iRE -> rptr and oCount unchanged; with the macro defined, oUdf=1. Simultaneous iWE+iRE while empty -> only the push is accepted and oCount=1.
REQ-037 Bench scenario: hold oCount at 2 and assert iWE+iRE together for 10 cycles with incrementing data -> oCount stays 2 and the popped data is in order across pointer wrap.
REQ-038 Bench scenario: while full, simultaneous iWE+iRE -> only the pop is accepted, oCount=3, and the pushed word is dropped.
REQ-039 Bench scenario: assert iRST with oCount=3 and iWE=1 -> next cycle oEmpty=1, oCount=0, no RAM write in the reset cycle, and error flags cleared.
